// File: rtl/add_arb_pkg.sv
// Shared constants for the round-robin adder arbiter: state encoding and datapath width.
package add_arb_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add8_core.sv
// Registered 8-bit ripple-carry adder; result appears one cycle after en, holds while en is low.
module add8_core
    import add_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] w_s;
    logic             w_c;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    always_comb begin
        w_s = '0;
        w_c = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            w_s[i] = a[i] ^ b[i] ^ w_c;
            w_c    = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (en) begin
            r_sum  <= w_s;
            r_cout <= w_c;
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: rtl/add_arb_rr.sv
// Round-robin share of one registered adder among NREQ level requesters.
// Grant one cycle after the request is sampled, done pulse one cycle later; losers wait while holding req.
module add_arb_rr
    import add_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      sum_out,
    output logic                  cout,
    output logic                  busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_idx;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_done;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    logic             w_any;
    logic [IW-1:0]    w_win;
    logic [IW-1:0]    w_j;
    logic             w_en;

    // Rotated priority search: first requester at or after r_ptr wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_j   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = IW'((int'(r_ptr) + k) % NREQ);
            if (!w_any && req[w_j]) begin
                w_any = 1'b1;
                w_win = w_j;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= EXEC;
                        r_idx   <= w_win;
                        r_gnt   <= NREQ'(1) << w_win;
                        r_a     <= a_in[w_win*WIDTH +: WIDTH];
                        r_b     <= b_in[w_win*WIDTH +: WIDTH];
                    end
                end
                EXEC: begin
                    r_state <= DONE;
                    r_done  <= r_gnt;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= '0;
                    r_gnt   <= '0;
                    r_ptr   <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= '0;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign w_en = (r_state == EXEC);

    add8_core u_add8_core (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_en),
        .a     (r_a),
        .b     (r_b),
        .sum   (sum_out),
        .cout  (cout)
    );

    assign gnt  = r_gnt;
    assign done = r_done;
    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_add_arb_rr.sv
// Scoreboarded bench for add_arb_rr: stimulus queues expected results, a negedge monitor checks every done pulse.
module tb_add_arb_rr;

    localparam int N = 4;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [N*8-1:0] a_in  = '0;
    logic [N*8-1:0] b_in  = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [7:0]     sum_out;
    logic           cout;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [3:0] oh;
        logic [7:0] sum;
        logic       cout;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [3:0] prev_done = '0;
    logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    always #5 clk = ~clk;

    add_arb_rr #(.NREQ(N), .WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .gnt     (gnt),
        .done    (done),
        .sum_out (sum_out),
        .cout    (cout),
        .busy    (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] oh, input logic [7:0] s, input logic c);
        exp_t e;
        e.oh   = oh;
        e.sum  = s;
        e.cout = c;
        exp_q.push_back(e);
    endtask

    // Lands #1 into the cycle after the next rising edge, which must be EXEC.
    task automatic expect_grant(input logic [3:0] oh);
        @(posedge clk);
        #1;
        chk("gnt", 32'(gnt), 32'(oh));
        chk("busy_exec", 32'(busy), 32'd1);
    endtask

    task automatic run_one(input int idx, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] a_late, input logic [7:0] esum,
                           input logic ecout, input bit withdraw);
        logic [3:0] oh;
        oh = 4'(1 << idx);
        req[idx] = 1'b1;
        a_in[idx*8 +: 8] = a;
        b_in[idx*8 +: 8] = b;
        push_exp(oh, esum, ecout);
        expect_grant(oh);
        a_in[idx*8 +: 8] = a_late;
        if (withdraw) req[idx] = 1'b0;
        @(posedge clk);
        #1;
        chk("done_k2", 32'(done), 32'(oh));
        req[idx] = 1'b0;
        @(posedge clk);
        #1;
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    always @(negedge clk) begin
        if (done !== '0) begin
            chk("done_single", 32'(prev_done), 32'd0);
            if (exp_q.size() == 0) begin
                chk("done_unexpected", 32'(done), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_oh", 32'(done), 32'(mon_e.oh));
                chk("gnt_at_done", 32'(gnt), 32'(mon_e.oh));
                chk("sum_out", 32'(sum_out), 32'(mon_e.sum));
                chk("cout", 32'(cout), 32'(mon_e.cout));
            end
        end
        prev_done = done;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // All four requesters held from reset
        req  = 4'b1111;
        a_in = {8'h44, 8'h33, 8'h22, 8'h11};
        b_in = {8'hF0, 8'h0E, 8'hE0, 8'h01};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum_out), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);

        push_exp(4'b0001, 8'h12, 1'b0);
        push_exp(4'b0010, 8'h02, 1'b1);
        push_exp(4'b0100, 8'h41, 1'b0);
        push_exp(4'b1000, 8'h34, 1'b1);
        push_exp(4'b0001, 8'h12, 1'b0);
        rst_n = 1'b1;
        for (int g = 0; g < 5; g++) begin
            expect_grant(order[g]);
            if (g == 4) req = '0;
            else repeat (2) @(posedge clk);
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("busy_after_rr", 32'(busy), 32'd0);

        run_one(0, 8'h12, 8'h34, 8'h12, 8'h46, 1'b0, 1'b0);
        run_one(2, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b0);
        run_one(1, 8'h80, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
        run_one(0, 8'h05, 8'h03, 8'h70, 8'h08, 1'b0, 1'b0);
        run_one(3, 8'hA5, 8'h5A, 8'hA5, 8'hFF, 1'b0, 1'b0);
        run_one(1, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0);

        // Reset during EXEC: nothing queued, so any done pulse is flagged
        req[3] = 1'b1;
        a_in[31:24] = 8'h01;
        b_in[31:24] = 8'h01;
        expect_grant(4'b1000);
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_sum", 32'(sum_out), 32'd0);
        chk("arst_cout", 32'(cout), 32'd0);
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Pointer restarts at 0: requester 0 beats 3, then 3 is served
        req = 4'b1001;
        a_in[7:0]   = 8'h0A;
        b_in[7:0]   = 8'h0B;
        a_in[31:24] = 8'h90;
        b_in[31:24] = 8'h90;
        push_exp(4'b0001, 8'h15, 1'b0);
        push_exp(4'b1000, 8'h20, 1'b1);
        expect_grant(4'b0001);
        repeat (2) @(posedge clk);
        expect_grant(4'b1000);
        req = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("busy_after_ptr", 32'(busy), 32'd0);

        run_one(1, 8'h21, 8'h43, 8'h21, 8'h64, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/add_arb_rr.md
# add_arb_rr

Round-robin controller that shares one registered 8-bit adder among `NREQ` requesters. Each requester raises a level request with its operands. The block grants one requester at a time, latches that requester's operands and sequences the adder enable. It then returns the registered sum and carry with a one-cycle done pulse to the winner. It sits between client blocks and the single adder instance, so no client drives the adder directly.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 8: operand width; fixed at 8 for this adder.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester level request; held high until that requester's `done` bit.
- `a_in`  in  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- `b_in`  in  NREQ*WIDTH  operand B, packed as `a_in`.
- `gnt`  out  NREQ  one-hot grant, registered; high from EXEC through DONE.
- `done`  out  NREQ  one-hot, one-cycle pulse in DONE; result valid this cycle.
- `sum_out`  out  WIDTH  registered sum, `(A+B) mod 256`; holds until the next DONE.
- `cout`  out  1  registered carry, bit 8 of A+B; holds with `sum_out`.
- `busy`  out  1  high when state ≠ IDLE.

## Operation
- The FSM has three states:
  - IDLE → EXEC when `req` ≠ 0.
  - EXEC → DONE unconditionally.
  - DONE → IDLE unconditionally.
- Arbitration happens only in IDLE:
  - Search order starts at `ptr`, then `ptr+1` … wrapping modulo NREQ.
  - The first requester with `req` high wins.
  - `ptr` resets to 0.
- On the IDLE→EXEC edge, the block registers:
  - `gnt` ← onehot(winner).
  - `a_in` and `b_in` slices of the winner into the operand registers.
  - `idx` ← winner.
- In EXEC, the adder enable is 1. The adder captures the sum and carry on the EXEC→DONE edge. In every other state the enable is 0 and the adder holds its value.
- In DONE:
  - `done[idx]` = 1.
  - `sum_out` and `cout` reflect the captured result.
- On the DONE→IDLE edge, `gnt` ← 0 and `ptr` ← `(idx+1) mod NREQ`.
- Arithmetic is unsigned. The sum is 9 bits internally: `sum_out` = [7:0] and `cout` = [8]. Wrap-around from 0xFF is normal, not an error.
- Boundary conditions:
  - **`req` dropped during EXEC or DONE:** the operation still completes and `done` still pulses. Operands were captured at the grant.
  - **Requester keeps `req` high after its `done`:** it is re-arbitrated with the lowest priority, because `ptr` has moved past it.
  - **Operand change after the grant:** ignored until the next grant.
  - **Several requests in the same cycle:** there is exactly one winner per the rotated order. The others wait; no request is lost while held.
  - **`rst_n` low at any time:** immediate return to IDLE. Reset values are `gnt`=0, `done`=0, `busy`=0, `sum_out`=0, `cout`=0, `ptr`=0 and operand registers 0. An in-flight operation is discarded with no `done`.

## Timing
- Let `req` be sampled high in IDLE at edge k:
  - `gnt` and `busy` are high in cycle k+1 (EXEC).
  - `done`, `sum_out` and `cout` are valid in cycle k+2 (DONE).
  - The block is back in IDLE in cycle k+3.
- Latency from request sample to result is 2 cycles. Throughput is one operation per 3 cycles.
- All outputs are registered or decoded from the state register only; there is no combinational path from `req` to any output.
- A requester must not treat `sum_out` as valid outside its `done` cycle.

## Structure
- Package `add_arb_pkg`:
  - state encoding constants IDLE=2'd0, EXEC=2'd1, DONE=2'd2;
  - `WIDTH` constant 8.
- Sub-module `add8_core`:
  - ports: `clk`, `rst_n`, `en`, `a`, `b`, `sum[7:0]`, `cout`;
  - registers the ripple-carry sum and carry when `en` is high;
  - reset value 0.
- The top level contains the FSM, the round-robin pointer and search, and the operand mux and registers.

## Test plan
- **Single request:** `req`=0001, A0=0x12, B0=0x34.
  - `gnt`=0001 at k+1.
  - `done`=0001, `sum_out`=0x46, `cout`=0 at k+2.
  - `busy` low at k+3.
- **Carry:** `req`=0100, A2=0xFF, B2=0x01.
  - `sum_out`=0x00, `cout`=1, `done`=0100.
- **Simultaneous requests:** `req`=1111 held continuously from reset.
  - Grants in order 0,1,2,3,0.
  - Successive grants are 3 cycles apart.
  - Each `done` is a single-cycle pulse.
- **Request withdrawn:** requester 1 drops `req` in EXEC with A1=0x80, B1=0x80.
  - `done`=0010, `sum_out`=0x00, `cout`=1 still occurs.
- **Reset mid-operation:** assert `rst_n`=0 during EXEC.
  - All outputs are 0 asynchronously.
  - No `done` pulse appears.
  - After release, `req`=0010 is granted (`ptr`=0 search order).
- **Operand change after grant:** change A0 from 0x05 to 0x70 in the EXEC cycle, with B0=0x03.
  - `sum_out`=0x08.
